sequence_driver: RTL and testbench
==================================

// Module: sequence_driver
// PURPOSE
//  Sequencer for the robot-game state_machine. Holds a loadable number sequence and
//  replays it one entry at a time onto state_machine.number. Samples state_display
//  after each step and stops on completion (2'b10) or game over (2'b11).
//  Sits between host/config logic and state_machine; replaces file-driven stimulus in silicon.
// PARAMETERS
//  DEPTH   6  max sequence entries
//  NUM_W   4  width of each number (matches state_machine.number)
//  SETTLE  1  cycles between number issue and state_display sample (1..15)
// PORTS
//  clock          in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-low reset
//  load_en        in   1               write load_data to mem[load_addr]; ignored unless IDLE
//  load_addr      in   $clog2(DEPTH)   write address; >= DEPTH ignored
//  load_data      in   NUM_W           sequence entry
//  seq_len        in   $clog2(DEPTH)+1 entries to play, captured on start; 0 or >DEPTH clamp to DEPTH
//  start          in   1               pulse: begin playback from entry 0 (IDLE/DONE/FAIL only)
//  abort          in   1               return to IDLE next cycle from any state
//  state_display  in   2               from state_machine
//  number         out  NUM_W           to state_machine.number
//  busy           out  1               high in ISSUE/WAIT
//  done           out  1               sticky in DONE until start/abort
//  game_over      out  1               sticky in FAIL until start/abort
//  step_idx       out  $clog2(DEPTH)   index of entry currently on number
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, number=0, busy=0, done=0,
//   game_over=0, step_idx=0, wait counter 0. Memory contents are NOT reset.
//  States: IDLE -> ISSUE on start. ISSUE (1 cycle): number<=mem[step_idx], load
//   counter=SETTLE -> WAIT. WAIT: decrement; at 0 sample state_display:
//   2'b11 -> FAIL; 2'b10 -> DONE; else if step_idx==len-1 -> DONE (exhausted);
//   else step_idx++ -> ISSUE.
//  Latency: entry k on number exactly (k*(SETTLE+1)) cycles after the ISSUE of entry 0.
//  number holds its last value in WAIT/DONE/FAIL; returns 0 only on reset/abort.
//  Priority: abort > start > state_display sample. abort same cycle as start -> IDLE.
//  start while busy: ignored. load_en while busy: ignored (memory is stable during play).
//  start from DONE/FAIL clears done/game_over and restarts at entry 0 next cycle.
//  2'b11 and 2'b10 both impossible simultaneously; 2'b11 checked first regardless.
//  step_idx never exceeds len-1; no wrap-around.
//  Reset mid-playback: immediate IDLE, outputs to reset values; playback not resumed.
// STRUCTURE
//  Shared package robot_pkg: localparams ST_PARTIAL=2'b01, ST_DONE=2'b10,
//   ST_OVER=2'b11, NUM_W; driver state enum {IDLE,ISSUE,WAIT,DONE,FAIL}.
//  One sub-module: seq_mem (DEPTH x NUM_W register file, 1 write/1 async read port).
//  Controller FSM + wait counter live in sequence_driver.
// TESTING
//  Load 1,2,3,4,5,6, len=6, model returns 01 each step -> number steps 1..6,
//   done=1 after 6th sample, game_over=0, step_idx=5.
//  Same load, model returns 11 after 3rd entry -> game_over=1, number holds 3, busy=0.
//  Model returns 10 after 2nd entry -> done=1, step_idx=1, entries 3..6 never issued.
//  abort asserted in WAIT of entry 2 -> IDLE next cycle, number=0, step_idx=0.
//  reset low mid-WAIT (async, between edges) -> outputs 0 immediately; memory intact:
//   start after release replays same 1..6.
//  seq_len=0 and seq_len=9 (DEPTH=6) -> both play 6 entries; load_addr=7 write ignored.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared definitions for the robot-game sequencer: state_display codes,
// number width and the driver controller state type.
package robot_pkg;

  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam int NUM_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    FAIL
  } drv_state_t;

endpackage

// File: rtl/sequence_driver_if.sv
// Host/config and state_machine side signals of the sequence driver.
// master: the side that loads, starts and answers with state_display.
// slave : the sequence driver itself.
interface sequence_driver_if #(
  parameter int DEPTH = 6,
  parameter int NUM_W = robot_pkg::NUM_W
);
  localparam int AW = $clog2(DEPTH);

  logic                load_en;
  logic [AW-1:0]       load_addr;
  logic [NUM_W-1:0]    load_data;
  logic [AW:0]         seq_len;
  logic                start;
  logic                abort;
  logic [1:0]          state_display;
  logic [NUM_W-1:0]    number;
  logic                busy;
  logic                done;
  logic                game_over;
  logic [AW-1:0]       step_idx;

  modport master (
    output load_en, load_addr, load_data, seq_len, start, abort, state_display,
    input  number, busy, done, game_over, step_idx
  );

  modport slave (
    input  load_en, load_addr, load_data, seq_len, start, abort, state_display,
    output number, busy, done, game_over, step_idx
  );
endinterface

// File: rtl/seq_mem.sv
// Sequence storage: DEPTH x NUM_W register file, one write port and one
// combinational read port. Contents are deliberately not reset so a loaded
// sequence survives a reset of the controller.
module seq_mem #(
  parameter int DEPTH = 6,
  parameter int NUM_W = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NUM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [NUM_W-1:0] rdata
);
  localparam int LW = AW + 1;

  logic [NUM_W-1:0] mem [DEPTH];

  // Write one entry; addresses beyond the last entry are dropped.
  always_ff @(posedge clock) begin
    if (we && ({1'b0, waddr} < LW'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < LW'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/sequence_driver.sv
// Sequencer that replays a loaded number sequence onto state_machine.number,
// one entry every SETTLE+1 cycles, and stops on completion, game over, or
// when the requested length is exhausted.
module sequence_driver #(
  parameter int DEPTH  = 6,
  parameter int NUM_W  = robot_pkg::NUM_W,
  parameter int SETTLE = 1
) (
  input logic              clock,
  input logic              reset,
  sequence_driver_if.slave bus
);
  import robot_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST_MAX   = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
  localparam logic [3:0]    SETTLE_CNT = 4'(SETTLE);

  drv_state_t       state_reg;
  logic [AW-1:0]    step_reg;
  logic [AW-1:0]    last_reg;
  logic [AW-1:0]    last_next;
  logic [3:0]       cnt_reg;
  logic [NUM_W-1:0] number_reg;
  logic [NUM_W-1:0] rd_data;
  logic             busy_reg;
  logic             done_reg;
  logic             over_reg;
  logic             mem_we;

  // Clamp the requested length (0 or oversize means full depth) to a last index.
  always_comb begin
    last_next = LAST_MAX;
    if (bus.seq_len != '0 && bus.seq_len <= DEPTH_L) begin
      last_next = AW'(bus.seq_len - LW'(1));
    end
  end

  // Memory is only writable while idle so it stays stable during playback.
  assign mem_we = bus.load_en && (state_reg == IDLE);

  seq_mem #(
    .DEPTH (DEPTH),
    .NUM_W (NUM_W),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (step_reg),
    .rdata (rd_data)
  );

  // Controller: abort beats start, start beats the state_display sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      last_reg   <= '0;
      cnt_reg    <= '0;
      number_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      over_reg   <= 1'b0;
    end else if (bus.abort) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      cnt_reg    <= '0;
      number_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      over_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            state_reg <= ISSUE;
            step_reg  <= '0;
            last_reg  <= last_next;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            over_reg  <= 1'b0;
          end
        end
        ISSUE: begin
          number_reg <= rd_data;
          cnt_reg    <= SETTLE_CNT;
          state_reg  <= WAIT;
        end
        WAIT: begin
          if (cnt_reg > 4'd1) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            cnt_reg <= '0;
            if (bus.state_display == ST_OVER) begin
              state_reg <= FAIL;
              over_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else if (bus.state_display == ST_DONE || step_reg == last_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              step_reg  <= step_reg + AW'(1);
              state_reg <= ISSUE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.number    = number_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.game_over = over_reg;
  assign bus.step_idx  = step_reg;

endmodule

// File: tb/tb_sequence_driver.sv
// Self-checking bench for sequence_driver: directed scenarios plus random
// playbacks checked against a behavioural model of the sequence rules.
module tb_sequence_driver;

  localparam int DEPTH  = 6;
  localparam int NUM_W  = 4;
  localparam int SETTLE = 2;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Model state: memory contents and the state_display answer for each step.
  logic [NUM_W-1:0] mem_m  [DEPTH];
  logic [1:0]       resp_m [DEPTH];

  sequence_driver_if #(.DEPTH(DEPTH), .NUM_W(NUM_W)) bus ();

  sequence_driver #(
    .DEPTH  (DEPTH),
    .NUM_W  (NUM_W),
    .SETTLE (SETTLE)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_resp_partial();
    for (int i = 0; i < DEPTH; i++) resp_m[i] = 2'b01;
  endtask

  // Write one entry; the model only takes it when the driver should accept it.
  task automatic do_load(input int addr, input int data, input bit idle);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_addr = 3'(addr);
    bus.load_data = 4'(data);
    @(negedge clk);
    bus.load_en = 1'b0;
    if (idle && addr < DEPTH) mem_m[addr] = 4'(data);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.number !== 4'd0 || bus.busy !== 1'b0 || bus.step_idx !== 3'd0) begin
      errors++;
      $display("FAIL go_idle: number=%0d busy=%0b step=%0d expected 0/0/0",
               bus.number, bus.busy, bus.step_idx);
    end
  endtask

  // Play with seq_len and resp_m; the model derives the stop step and outcome.
  task automatic play(input int len_in, input bit poke, input string tag);
    int n;
    int stop_k;
    bit fail_end;
    n = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    stop_k = n - 1;
    fail_end = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (resp_m[k] == 2'b11 || resp_m[k] == 2'b10) begin
        stop_k = k;
        fail_end = (resp_m[k] == 2'b11);
        break;
      end
    end
    @(negedge clk);
    bus.seq_len = 4'(len_in);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%0b done=%0b over=%0b expected 1/0/0",
               tag, bus.busy, bus.done, bus.game_over);
    end
    for (int k = 0; k <= stop_k; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.number !== mem_m[k] || bus.step_idx !== 3'(k)) begin
        errors++;
        $display("FAIL %s entry %0d: number=%0d step=%0d expected %0d/%0d",
                 tag, k, bus.number, bus.step_idx, mem_m[k], k);
      end
      bus.state_display = resp_m[k];
      if (poke && k == 1) bus.start = 1'b1;
      for (int w = 0; w < SETTLE; w++) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      if (k < stop_k) begin
        checks++;
        if (bus.step_idx !== 3'(k + 1) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s advance %0d: step=%0d busy=%0b expected %0d/1",
                   tag, k, bus.step_idx, bus.busy, k + 1);
        end
        bus.state_display = 2'b01;
      end
    end
    bus.state_display = 2'b01;
    checks++;
    if (bus.done !== !fail_end || bus.game_over !== fail_end || bus.busy !== 1'b0 ||
        bus.number !== mem_m[stop_k] || bus.step_idx !== 3'(stop_k)) begin
      errors++;
      $display("FAIL %s end: done=%0b over=%0b busy=%0b number=%0d step=%0d expected %0b/%0b/0/%0d/%0d",
               tag, bus.done, bus.game_over, bus.busy, bus.number, bus.step_idx,
               !fail_end, fail_end, mem_m[stop_k], stop_k);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.number !== mem_m[stop_k] || bus.busy !== 1'b0 || bus.done !== !fail_end) begin
      errors++;
      $display("FAIL %s hold: number=%0d busy=%0b done=%0b expected %0d/0/%0b",
               tag, bus.number, bus.busy, bus.done, mem_m[stop_k], !fail_end);
    end
    $display("play %s: len=%0d entries=%0d outcome=%s", tag, len_in, stop_k + 1,
             fail_end ? "game_over" : "done");
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.number !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.game_over !== 1'b0 || bus.step_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset: number=%0d busy=%0b done=%0b over=%0b step=%0d expected all 0",
               bus.number, bus.busy, bus.done, bus.game_over, bus.step_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_full_play();
    for (int i = 0; i < DEPTH; i++) do_load(i, i + 1, 1'b1);
    set_resp_partial();
    play(6, 1'b0, "full");
  endtask

  task automatic test_game_over();
    set_resp_partial();
    resp_m[2] = 2'b11;
    play(6, 1'b0, "game_over");
  endtask

  task automatic test_early_done();
    set_resp_partial();
    resp_m[1] = 2'b10;
    play(6, 1'b0, "early_done");
  endtask

  // Restart straight from DONE; also loads attempted outside IDLE are dropped.
  task automatic test_back_to_back();
    set_resp_partial();
    do_load(0, 9, 1'b0);
    play(4, 1'b0, "restart_from_done");
    play(6, 1'b1, "start_while_busy");
  endtask

  task automatic test_abort();
    go_idle();
    set_resp_partial();
    @(negedge clk);
    bus.seq_len = 4'd6;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (1 + SETTLE + 1) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if (bus.number !== 4'd0 || bus.step_idx !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: number=%0d step=%0d busy=%0b expected 0/0/0",
               bus.number, bus.step_idx, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.number !== 4'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stay: number=%0d busy=%0b expected 0/0", bus.number, bus.busy);
    end
    $display("abort: idle after abort in WAIT of entry 2");
  endtask

  task automatic test_reset_mid();
    set_resp_partial();
    @(negedge clk);
    bus.seq_len = 4'd6;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (1 + SETTLE + 1) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.number !== 4'd0 || bus.busy !== 1'b0 || bus.step_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: number=%0d busy=%0b step=%0d expected 0/0/0",
               bus.number, bus.busy, bus.step_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset_mid: outputs cleared asynchronously");
    play(6, 1'b0, "after_reset");
  endtask

  task automatic test_len_clamp();
    go_idle();
    do_load(7, 15, 1'b1);
    do_load(6, 14, 1'b1);
    set_resp_partial();
    play(0, 1'b0, "len0");
    play(9, 1'b0, "len9");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      go_idle();
      for (int j = 0; j < 5; j++) begin
        do_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b1);
      end
      for (int k = 0; k < DEPTH; k++) begin
        int r;
        r = int'($urandom_range(0, 19));
        resp_m[k] = (r == 0) ? 2'b11 : (r == 1) ? 2'b10 : (r[0] ? 2'b01 : 2'b00);
      end
      play(int'($urandom_range(0, 15)), 1'b0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    bus.load_en       = 1'b0;
    bus.load_addr     = '0;
    bus.load_data     = '0;
    bus.seq_len       = '0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.state_display = 2'b01;
    test_reset();
    test_full_play();
    test_game_over();
    test_early_done();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_len_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
